// File: rtl/mul_seq_ctrl_pkg.sv
// Shared constants for the sequential multiply controller: operand width,
// execute-command encodings and the controller state type.
package mul_seq_ctrl_pkg;

  localparam int WORD_LEN    = 16;
  localparam int EXE_CMD_LEN = 4;

  localparam logic [EXE_CMD_LEN-1:0] EXE_NOP = 4'd0;
  localparam logic [EXE_CMD_LEN-1:0] EXE_ADD = 4'd1;
  localparam logic [EXE_CMD_LEN-1:0] EXE_MUL = 4'd12;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_shift_add_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into
// the upper half of the partial product, then shift {carry,P,B} right by one.
module mul_shift_add_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_p,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_p,
  output logic [W-1:0] o_b
);

  logic [W:0] w_sum;

  // The sum is one bit wider than P so the carry out is kept and the product stays exact
  always_comb begin
    w_sum = {1'b0, i_p};
    if (i_b[0]) begin
      w_sum = {1'b0, i_p} + {1'b0, i_a};
    end
  end

  assign o_p = w_sum[W:1];
  assign o_b = {w_sum[0], i_b[W-1:1]};

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle unsigned multiply controller for the execute stage. Latches the
// operands when a multiply is issued, iterates WORD_LEN shift-add steps while
// stalling the pipeline, then commits the double-width product to HI/LO.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int WORD_LEN    = mul_seq_ctrl_pkg::WORD_LEN,
  parameter int EXE_CMD_LEN = mul_seq_ctrl_pkg::EXE_CMD_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXE_CMD_LEN-1:0] EXE_CMD,
  input  logic [WORD_LEN-1:0]    val1,
  input  logic [WORD_LEN-1:0]    val2,
  input  logic                   flush,
  output logic                   stall,
  output logic                   busy,
  output logic                   done,
  output logic [WORD_LEN-1:0]    lo,
  output logic [WORD_LEN-1:0]    hi
);

  localparam int CNT_W = $clog2(WORD_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WORD_LEN - 1);

  mul_state_t          r_state;
  logic [WORD_LEN-1:0] r_a;
  logic [WORD_LEN-1:0] r_b;
  logic [WORD_LEN-1:0] r_p;
  logic [CNT_W-1:0]    r_count;
  logic [WORD_LEN-1:0] r_hi;
  logic [WORD_LEN-1:0] r_lo;

  logic                w_start;
  logic [WORD_LEN-1:0] w_next_p;
  logic [WORD_LEN-1:0] w_next_b;

  assign w_start = (EXE_CMD == EXE_CMD_LEN'(EXE_MUL)) && !flush;

  mul_shift_add_step #(
    .W (WORD_LEN)
  ) u_step (
    .i_a (r_a),
    .i_p (r_p),
    .i_b (r_b),
    .o_p (w_next_p),
    .o_b (w_next_b)
  );

  // Controller FSM with iteration counter, datapath registers and HI/LO commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= MUL_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        MUL_IDLE: begin
          if (w_start) begin
            r_a     <= val1;
            r_b     <= val2;
            r_p     <= '0;
            r_count <= '0;
            r_state <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          if (flush) begin
            r_state <= MUL_IDLE;
          end else begin
            r_p     <= w_next_p;
            r_b     <= w_next_b;
            r_count <= r_count + 1'b1;
            if (r_count == LAST_COUNT) begin
              r_hi    <= w_next_p;
              r_lo    <= w_next_b;
              r_state <= MUL_DONE;
            end
          end
        end
        MUL_DONE: begin
          r_state <= MUL_IDLE;
        end
        default: begin
          r_state <= MUL_IDLE;
        end
      endcase
    end
  end

  // Stall must rise in the issue cycle itself, so it is decoded combinationally
  always_comb begin
    stall = ((r_state == MUL_IDLE) && w_start) || (r_state == MUL_RUN);
    busy  = (r_state == MUL_RUN);
    done  = (r_state == MUL_DONE);
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed corner products, random
// products against a plain-arithmetic model, back-to-back issue, flush,
// asynchronous reset and non-multiply commands.
module tb_mul_seq_ctrl;
  import mul_seq_ctrl_pkg::*;

  localparam int W = mul_seq_ctrl_pkg::WORD_LEN;
  localparam int EXP_STALL = W + 1;
  localparam int EXP_DONE_CYCLE = W + 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [EXE_CMD_LEN-1:0] EXE_CMD;
  logic [W-1:0]           val1;
  logic [W-1:0]           val2;
  logic                   flush;
  logic                   stall;
  logic                   busy;
  logic                   done;
  logic [W-1:0]           lo;
  logic [W-1:0]           hi;

  int checks = 0;
  int failures = 0;
  int doneTotal = 0;
  logic [2*W-1:0] lastProd = '0;

  mul_seq_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .EXE_CMD (EXE_CMD),
    .val1    (val1),
    .val2    (val2),
    .flush   (flush),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .lo      (lo),
    .hi      (hi)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Count every completed multiply across the whole run
  always @(posedge clk) begin
    if (done === 1'b1) doneTotal <= doneTotal + 1;
  end

  // Issue one multiply and follow it until the done pulse, scrambling the
  // operand inputs while it runs; returns in the done cycle.
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int stallCycles, output int doneCycle,
                        output logic [W-1:0] hiObs, output logic [W-1:0] loObs,
                        output bit timedOut);
    stallCycles = 0;
    doneCycle = -1;
    hiObs = '0;
    loObs = '0;
    timedOut = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    EXE_CMD = EXE_MUL;
    val1 = a;
    val2 = b;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stall === 1'b1) stallCycles++;
      if (done === 1'b1) begin
        doneCycle = c;
        hiObs = hi;
        loObs = lo;
        timedOut = 1'b0;
        break;
      end
      @(negedge clk);
      val1 = W'($urandom);
      val2 = W'($urandom);
    end
    if (timedOut) EXE_CMD = EXE_NOP;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    EXE_CMD = EXE_NOP;
    val1 = '0;
    val2 = '0;
    flush = 1'b0;
    #1;
    checks++;
    if ({stall, busy, done} !== 3'b000 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("[TB] FAIL reset_values got stall=%b busy=%b done=%b hi=%h lo=%h want all zero",
               stall, busy, done, hi, lo);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({stall, busy, done} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL idle_after_reset got stall=%b busy=%b done=%b want 000", stall, busy, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [5] = '{16'h0003, 16'hFFFF, 16'h8000, 16'h0000, 16'h1234};
    logic [W-1:0] vb [5] = '{16'h0005, 16'hFFFF, 16'h0002, 16'h1234, 16'h0000};
    int stallCycles, doneCycle;
    logic [W-1:0] hiObs, loObs;
    logic [2*W-1:0] expProd;
    bit timedOut;
    for (int i = 0; i < 5; i++) begin
      expProd = (2*W)'(va[i]) * (2*W)'(vb[i]);
      do_mul(va[i], vb[i], stallCycles, doneCycle, hiObs, loObs, timedOut);
      checks++;
      if (timedOut) begin
        failures++;
        $display("[TB] FAIL directed_timeout vec=%0d no done within 40 cycles", i);
      end
      checks++;
      if (stallCycles != EXP_STALL || doneCycle != EXP_DONE_CYCLE) begin
        failures++;
        $display("[TB] FAIL directed_timing vec=%0d got stall=%0d done_cycle=%0d want stall=%0d done_cycle=%0d",
                 i, stallCycles, doneCycle, EXP_STALL, EXP_DONE_CYCLE);
      end
      checks++;
      if ({hiObs, loObs} !== expProd) begin
        failures++;
        $display("[TB] FAIL directed_product vec=%0d %h*%h got %h_%h want %h",
                 i, va[i], vb[i], hiObs, loObs, expProd);
      end
      lastProd = expProd;
      @(negedge clk);
      EXE_CMD = EXE_NOP;
      #1;
      checks++;
      if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL directed_idle vec=%0d got busy=%b stall=%b done=%b want 000",
                 i, busy, stall, done);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, hiObs, loObs;
    logic [2*W-1:0] expProd;
    int stallCycles, doneCycle;
    bit timedOut;
    for (int i = 0; i < 12; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      expProd = (2*W)'(a) * (2*W)'(b);
      do_mul(a, b, stallCycles, doneCycle, hiObs, loObs, timedOut);
      checks++;
      if (timedOut || stallCycles != EXP_STALL || doneCycle != EXP_DONE_CYCLE) begin
        failures++;
        $display("[TB] FAIL random_timing iter=%0d got timeout=%0d stall=%0d done_cycle=%0d want 0/%0d/%0d",
                 i, timedOut, stallCycles, doneCycle, EXP_STALL, EXP_DONE_CYCLE);
      end
      checks++;
      if ({hiObs, loObs} !== expProd) begin
        failures++;
        $display("[TB] FAIL random_product iter=%0d %h*%h got %h_%h want %h", i, a, b, hiObs, loObs, expProd);
      end
      lastProd = expProd;
      @(negedge clk);
      EXE_CMD = EXE_NOP;
    end
  endtask

  task automatic test_back_to_back();
    int stallCycles, doneCycle, doneBefore;
    logic [W-1:0] hiObs, loObs;
    bit timedOut;
    doneBefore = doneTotal;
    do_mul(16'd7, 16'd9, stallCycles, doneCycle, hiObs, loObs, timedOut);
    checks++;
    if (timedOut || hiObs !== 16'h0000 || loObs !== 16'h003F) begin
      failures++;
      $display("[TB] FAIL b2b_first got timeout=%0d hi=%h lo=%h want 0/0000/003f", timedOut, hiObs, loObs);
    end
    do_mul(16'h0100, 16'h0100, stallCycles, doneCycle, hiObs, loObs, timedOut);
    checks++;
    if (timedOut || stallCycles != EXP_STALL || doneCycle != EXP_DONE_CYCLE) begin
      failures++;
      $display("[TB] FAIL b2b_second_timing got timeout=%0d stall=%0d done_cycle=%0d want 0/%0d/%0d",
               timedOut, stallCycles, doneCycle, EXP_STALL, EXP_DONE_CYCLE);
    end
    checks++;
    if (hiObs !== 16'h0001 || loObs !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL b2b_second_product got hi=%h lo=%h want 0001/0000", hiObs, loObs);
    end
    lastProd = 32'h0001_0000;
    @(negedge clk);
    EXE_CMD = EXE_NOP;
    repeat (3) @(negedge clk);
    checks++;
    if (doneTotal - doneBefore != 2) begin
      failures++;
      $display("[TB] FAIL b2b_done_pulses got %0d want 2", doneTotal - doneBefore);
    end
  endtask

  task automatic test_flush();
    int doneBefore, badCycles;
    // flush while idle must swallow the issue
    @(negedge clk);
    EXE_CMD = EXE_MUL;
    val1 = 16'h0033;
    val2 = 16'h0044;
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_idle_stall got %b want 0", stall);
    end
    @(negedge clk);
    EXE_CMD = EXE_NOP;
    flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_idle_start got busy=%b want 0", busy);
    end
    // flush during the fifth RUN cycle aborts without committing
    doneBefore = doneTotal;
    @(negedge clk);
    EXE_CMD = EXE_MUL;
    val1 = 16'h1234;
    val2 = 16'h0010;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || stall !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_run_state got busy=%b stall=%b want 1/1", busy, stall);
    end
    @(negedge clk);
    flush = 1'b0;
    EXE_CMD = EXE_NOP;
    #1;
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_abort got busy=%b stall=%b want 0/0", busy, stall);
    end
    badCycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || {hi, lo} !== lastProd) badCycles++;
    end
    checks++;
    if (badCycles != 0 || doneTotal != doneBefore) begin
      failures++;
      $display("[TB] FAIL flush_no_commit got bad_cycles=%0d extra_done=%0d hi_lo=%h want 0/0/%h",
               badCycles, doneTotal - doneBefore, {hi, lo}, lastProd);
    end
  endtask

  task automatic test_async_reset();
    int stallCycles, doneCycle;
    logic [W-1:0] hiObs, loObs, a, b;
    bit timedOut;
    // start a multiply, then reset it between clock edges
    @(negedge clk);
    EXE_CMD = EXE_MUL;
    val1 = 16'h00AB;
    val2 = 16'h0CD0;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    EXE_CMD = EXE_NOP;
    #1;
    checks++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset got hi=%h lo=%h busy=%b stall=%b done=%b want all zero",
               hi, lo, busy, stall, done);
    end
    lastProd = '0;
    @(negedge clk);
    rst = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    do_mul(a, b, stallCycles, doneCycle, hiObs, loObs, timedOut);
    checks++;
    if (timedOut || doneCycle != EXP_DONE_CYCLE || {hiObs, loObs} !== (2*W)'(a) * (2*W)'(b)) begin
      failures++;
      $display("[TB] FAIL after_reset_mul got timeout=%0d done_cycle=%0d product=%h_%h want %h",
               timedOut, doneCycle, hiObs, loObs, (2*W)'(a) * (2*W)'(b));
    end
    lastProd = (2*W)'(a) * (2*W)'(b);
    @(negedge clk);
    EXE_CMD = EXE_NOP;
  endtask

  task automatic test_non_mul();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      EXE_CMD = EXE_ADD;
      val1 = W'($urandom);
      val2 = W'($urandom);
      #1;
      checks++;
      if (stall !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== lastProd) begin
        failures++;
        $display("[TB] FAIL add_no_effect cycle=%0d got stall=%b busy=%b done=%b hi_lo=%h want 0/0/0/%h",
                 c, stall, busy, done, {hi, lo}, lastProd);
      end
    end
    @(negedge clk);
    EXE_CMD = EXE_NOP;
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_non_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Multi-cycle multiply controller for the execute stage. It accepts the multiply command when the ALU decode issues it, runs a radix-2 unsigned shift-add over `WORD_LEN` cycles and holds the pipeline stalled meanwhile. It then writes the double-width product to dedicated HI/LO registers. It replaces the single-cycle combinational multiply path, so the ALU needs no full-width multiplier.

## Interface
Parameters:
- `WORD_LEN`, default `` `WORD_LEN `` (16): operand and half-result width.
- `EXE_CMD_LEN`, default `` `EXE_CMD_LEN ``: width of the execute command.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `EXE_CMD`  in  `EXE_CMD_LEN`  execute command of the instruction in EX.
- `val1`  in  `WORD_LEN`  multiplicand (forwarded operand).
- `val2`  in  `WORD_LEN`  multiplier (forwarded operand).
- `flush`  in  1  abort the in-flight multiply (branch/exception flush).
- `stall`  out  1  freeze IF/ID/EX pipeline registers.
- `busy`  out  1  FSM is in RUN.
- `done`  out  1  one-cycle pulse: HI/LO updated this cycle.
- `lo`  out  `WORD_LEN`  product[`WORD_LEN`-1:0], registered.
- `hi`  out  `WORD_LEN`  product[2·`WORD_LEN`-1:`WORD_LEN`], registered.

## Operation
- States:
  - IDLE: `start` = (`EXE_CMD` == `` `EXE_MUL ``) && !`flush`. On `start`: load multiplicand A←`val1`, multiplier B←`val2`, accumulator P←0, count←0, go to RUN.
  - RUN: each cycle, if B[0] add A to the upper half of P. Then shift {carry,P,B} right by one, count++. When count == `WORD_LEN`-1 this cycle: write `hi`/`lo` from the final product and go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE unconditionally.
- Arithmetic: unsigned. The accumulator carries one extra bit, so the product is exact; no overflow exists.
- `stall` = (IDLE && `start`) || RUN. It is combinational and is low in DONE, so the multiply instruction leaves EX on the edge ending DONE.
- `EXE_MUL` seen in DONE is ignored: it is the same instruction still held in EX. New commands are accepted only in IDLE.
- `flush` in RUN: go to IDLE next edge; `hi`/`lo` unchanged, no `done`. `flush` in IDLE suppresses `start`. `flush` in DONE has no effect, because HI/LO are already committed.
- Operand changes on `val1`/`val2` during RUN are ignored; operands are latched at start.
- Non-multiply commands: no effect, `stall`=0.

## Timing
- Reset values: state IDLE, `stall`=0 (given no start), `busy`=0, `done`=0, `hi`=0, `lo`=0, count=0, A/B/P=0.
- Reset asserted mid-RUN aborts immediately (asynchronous); HI/LO return to 0.
- Latency: start sampled at edge E0. RUN occupies cycles after edges E0..E(`WORD_LEN`-1). HI/LO change at edge E`WORD_LEN`, and DONE is that following cycle.
- For `WORD_LEN`=16: `stall` is high for 17 cycles (start cycle + 16 RUN), `done` is high in cycle 17, and IDLE resumes at cycle 18.
- Back-to-back multiplies: the second is accepted in the first IDLE cycle after DONE. There are no lost or duplicated starts.
- Counter width: clog2(`WORD_LEN`)+1 bits; no wrap during RUN.

## Structure
- Shared `defines.v` holds `` `WORD_LEN ``, `` `EXE_CMD_LEN `` and `` `EXE_MUL ``. The state encodings (IDLE, RUN, DONE, 2 bits) are added there as `` `MUL_IDLE ``/`` `MUL_RUN ``/`` `MUL_DONE ``.
- One natural sub-module: `mul_shift_add_step`, combinational, with inputs A, P, B and outputs the next {P,B}. The FSM, counter and HI/LO registers stay in `mul_seq_ctrl`.
- The ALU keeps `` `EXE_MUL `` returning `lo` via the existing result mux. The hazard unit ORs `stall` into its freeze signal.

## Test plan
- 3×5 (`WORD_LEN`=16): `stall` high 17 cycles, `done` pulse in cycle 17, `hi`=0x0000, `lo`=0x000F.
- 0xFFFF×0xFFFF: `hi`=0xFFFE, `lo`=0x0001; 0x8000×0x0002: `hi`=0x0001, `lo`=0x0000; 0×0x1234: both 0.
- Back-to-back 7×9 then 0x0100×0x0100: `lo`=0x003F after the first `done`. The second starts the cycle after DONE and gives `hi`=0x0001, `lo`=0x0000. Exactly two `done` pulses.
- `flush` at RUN cycle 5 of 0x1234×0x0010: IDLE next edge, no `done`, `hi`/`lo` keep the prior values, `stall` drops.
- Async `rst` pulse mid-RUN (between clock edges): outputs zero immediately, state IDLE. The next `EXE_MUL` completes normally.
- `EXE_ADD` with arbitrary operands: `stall`=0 and `busy`=0, and `hi`/`lo` unchanged throughout.
